// File: rtl/addsub_sequencer.sv
// Sequences one shared carry-less adder to serve ADD and two-pass SUB for two
// round-robin requesters, presenting results with overflow/zero flags.
module addsub_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sub,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sub,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] adder_x,
    output logic [WIDTH-1:0] adder_y,
    input  logic [WIDTH-1:0] adder_sum,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {IDLE, NEG, ADD, RESP} state_t;

    state_t           state_reg;
    logic             last_grant_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;
    logic             id_reg;
    logic [WIDTH-1:0] adder_x_reg;
    logic [WIDTH-1:0] adder_y_reg;
    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_ovf_reg;
    logic             rsp_zero_reg;

    logic [1:0]       valid_vec;
    logic [1:0]       ready_vec;
    logic [1:0]       sub_vec;
    logic [WIDTH-1:0] a_vec [2];
    logic [WIDTH-1:0] b_vec [2];
    logic             grant_id;
    logic             accept;
    logic             ovf_next;

    assign valid_vec = {req1_valid, req0_valid};
    assign sub_vec   = {req1_sub, req0_sub};
    assign a_vec[0]  = req0_a;
    assign a_vec[1]  = req1_a;
    assign b_vec[0]  = req0_b;
    assign b_vec[1]  = req1_b;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant_id = valid_vec[1];
        if (valid_vec == 2'b11) begin
            grant_id = ~last_grant_reg;
        end
    end

    assign accept = (state_reg == IDLE) && (|valid_vec) && !clr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = accept && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // Flags are judged against the original B, not its negation.
    always_comb begin
        ovf_next = 1'b0;
        if (sub_reg) begin
            ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (adder_sum[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
            ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (adder_sum[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
            sub_reg        <= 1'b0;
            id_reg         <= 1'b0;
            adder_x_reg    <= '0;
            adder_y_reg    <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_ovf_reg    <= 1'b0;
            rsp_zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg          <= a_vec[grant_id];
                        b_reg          <= b_vec[grant_id];
                        sub_reg        <= sub_vec[grant_id];
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        if (sub_vec[grant_id]) begin
                            state_reg   <= NEG;
                            adder_x_reg <= ~b_vec[grant_id];
                            adder_y_reg <= {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            state_reg   <= ADD;
                            adder_x_reg <= a_vec[grant_id];
                            adder_y_reg <= b_vec[grant_id];
                        end
                    end
                end
                NEG: begin
                    // adder_y itself holds -B through the ADD pass.
                    state_reg   <= ADD;
                    adder_x_reg <= a_reg;
                    adder_y_reg <= adder_sum;
                end
                ADD: begin
                    state_reg      <= RESP;
                    adder_x_reg    <= '0;
                    adder_y_reg    <= '0;
                    rsp_valid_reg  <= 1'b1;
                    rsp_id_reg     <= id_reg;
                    rsp_result_reg <= adder_sum;
                    rsp_ovf_reg    <= ovf_next;
                    rsp_zero_reg   <= (adder_sum == '0);
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg      <= IDLE;
                        rsp_valid_reg  <= 1'b0;
                        rsp_id_reg     <= 1'b0;
                        rsp_result_reg <= '0;
                        rsp_ovf_reg    <= 1'b0;
                        rsp_zero_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign adder_x    = adder_x_reg;
    assign adder_y    = adder_y_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_ovf    = rsp_ovf_reg;
    assign rsp_zero   = rsp_zero_reg;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed-vector bench for addsub_sequencer with a behavioural shared adder.
module tb_addsub_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic [31:0] adder_x, adder_y, adder_sum;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_zero;
    logic [31:0] rsp_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign adder_sum = adder_x + adder_y;

    addsub_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_a(req1_a), .req1_b(req1_b),
        .adder_x(adder_x), .adder_y(adder_y), .adder_sum(adder_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
    task automatic do_op(input string tag, input bit id, input bit sub,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit exp_ovf,
                         input bit exp_zero, input int exp_lat);
        int n;
        bit got;
        logic [31:0] nb;
        nb = ~b + 32'd1;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_sub = sub; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_sub = sub; req0_a = a; req0_b = b;
        end
        #1;
        check({tag, " ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'hDEADBEEF; req0_b = 32'h12345678;
        req1_a = 32'hCAFEF00D; req1_b = 32'h0BADF00D;
        n = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (sub && n == 1) begin
                check({tag, " neg_x"}, adder_x, ~b);
                check({tag, " neg_y"}, adder_y, 32'd1);
            end
            if (n == exp_lat - 1) begin
                check({tag, " add_x"}, adder_x, a);
                check({tag, " add_y"}, adder_y, sub ? nb : b);
            end
            if (rsp_valid) got = 1'b1;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " id"}, {31'd0, rsp_id}, {31'd0, id});
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " ovf"}, {31'd0, rsp_ovf}, {31'd0, exp_ovf});
        check({tag, " zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
        @(negedge clk);
        check({tag, " drop"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " clear"}, rsp_result, 32'd0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int   cnt;
        logic exp_ids [4];
        logic [31:0] exp_res [4];

        clr = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b0; req1_sub = 1'b0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready0", {31'd0, req0_ready}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset adder_x", adder_x, 32'd0);
        check("reset adder_y", adder_y, 32'd0);
        check("reset result", rsp_result, 32'd0);
        req0_valid = 1'b0;
        clr = 1'b0;

        do_op("sub5-3", 1'b0, 1'b1, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 3);
        do_op("add7fff+1", 1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 2);
        do_op("sub0-8000", 1'b0, 1'b1, 32'd0, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 3);
        do_op("sub8000-1", 1'b1, 1'b1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 3);
        do_op("add-1+1", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 2);

        // Round robin with both requesters held valid, starting from reset.
        do_clr();
        exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
        exp_res[0] = 32'd2; exp_res[1] = 32'd0; exp_res[2] = 32'd2; exp_res[3] = 32'd0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_sub = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check($sformatf("rr%0d id", cnt), {31'd0, rsp_id}, {31'd0, exp_ids[cnt]});
                check($sformatf("rr%0d result", cnt), rsp_result, exp_res[cnt]);
                check($sformatf("rr%0d zero", cnt), {31'd0, rsp_zero}, {31'd0, exp_ids[cnt]});
                cnt++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr count", cnt, 32'd4);
        @(negedge clk);

        // Held response: 0-1 with the consumer stalled for five cycles.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b1; req0_a = 32'd0; req0_b = 32'd1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("hold latency", cnt, 32'd3);
        for (int k = 0; k < 5; k++) begin
            req1_valid = 1'b1; req1_sub = 1'b0; req1_a = k; req1_b = k;
            #1;
            check($sformatf("hold%0d valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("hold%0d result", k), rsp_result, 32'hFFFFFFFF);
            check($sformatf("hold%0d id", k), {31'd0, rsp_id}, 32'd0);
            check($sformatf("hold%0d ready1", k), {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("hold ovf", {31'd0, rsp_ovf}, 32'd0);
        @(negedge clk);
        check("hold done", {31'd0, rsp_valid}, 32'd0);

        // clr during NEG of a req0 SUB, then both pending: req0 must win.
        do_clr();
        req0_valid = 1'b1; req0_sub = 1'b1; req0_a = 32'd9; req0_b = 32'd2;
        @(posedge clk);
        #1;
        req0_sub = 1'b0; req0_a = 32'd10; req0_b = 32'd20;
        req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 32'd7; req1_b = 32'd8;
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr neg ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        check("clr rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("clr adder_x", adder_x, 32'd0);
        clr = 1'b0;
        #1;
        check("clr after ready0", {31'd0, req0_ready}, 32'd1);
        check("clr after ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("clr next id", {31'd0, rsp_id}, 32'd0);
        check("clr next result", rsp_result, 32'd30);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
